// File: rtl/seq_detect_1011.sv
// rtl/seq_detect_1011.sv - Moore detector for serial pattern 1011 with saturating match counter
//
// Purpose:
//   Watches a qualified serial bit stream for the pattern 1011. A one-cycle
//   detect pulse follows the edge that completes the pattern. A saturating
//   counter records how many matches have occurred since reset or clear.
//   OVERLAP selects whether the tail of a match may start the next one.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset, overrides all other inputs
//   bit_in       serial data bit
//   bit_valid    bit_in is consumed only on edges where this is 1
//   count_clr    synchronous clear of match_count
//   detect       registered one-cycle match pulse
//   match_count  saturating number of matches
//   state_dbg    current FSM state code

module seq_detect_1011 #(
  parameter int OVERLAP = 1,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             count_clr,
  output logic             detect,
  output logic [CNT_W-1:0] match_count,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    S0    = 3'd0,
    S1    = 3'd1,
    S10   = 3'd2,
    S101  = 3'd3,
    S1011 = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic             detect_q, detect_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             match;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S0;
      detect_q <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      detect_q <= detect_d;
      count_q  <= count_d;
    end
  end

  // Next-state logic. The illegal codes fall into the default branch and
  // return to S0 on the next edge even when no bit is being consumed.
  always_comb begin
    state_d = state_q;
    match   = 1'b0;
    case (state_q)
      S0: begin
        if (bit_valid) begin
          state_d = bit_in ? S1 : S0;
        end
      end
      S1: begin
        if (bit_valid) begin
          state_d = bit_in ? S1 : S10;
        end
      end
      S10: begin
        if (bit_valid) begin
          state_d = bit_in ? S101 : S0;
        end
      end
      S101: begin
        if (bit_valid) begin
          if (bit_in) begin
            state_d = S1011;
            match   = 1'b1;
          end else begin
            state_d = S10;
          end
        end
      end
      S1011: begin
        // With overlap the trailing 1 of the match acts as the leading 1
        // of the next pattern, so a 0 leaves us having seen "10".
        if (bit_valid) begin
          if (bit_in) begin
            state_d = S1;
          end else if (OVERLAP != 0) begin
            state_d = S10;
          end else begin
            state_d = S0;
          end
        end
      end
      default: begin
        state_d = S0;
      end
    endcase
  end

  // The pulse is tied to the entry edge rather than to residence in S1011,
  // so holding in S1011 with bit_valid low produces no repeat pulse.
  always_comb begin
    detect_d = match;
  end

  // A clear coinciding with a match still records that match.
  always_comb begin
    count_d = count_q;
    if (count_clr) begin
      count_d = match ? {{(CNT_W-1){1'b0}}, 1'b1} : '0;
    end else if (match && (count_q != CNT_MAX)) begin
      count_d = count_q + 1'b1;
    end
  end

  assign detect      = detect_q;
  assign match_count = count_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_seq_detect_1011.sv
// tb/tb_seq_detect_1011.sv - self-checking bench for seq_detect_1011 against a bit-history model

module tb_seq_detect_1011;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       bit_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic       count_clr = 1'b0;

  logic       det_ov, det_no, det_c2;
  logic [7:0] cnt_ov, cnt_no;
  logic [1:0] cnt_c2;
  logic [2:0] st_ov, st_no, st_c2;

  int nchecks = 0;
  int nerr    = 0;

  always #5 clk = ~clk;

  seq_detect_1011 #(.OVERLAP(1), .CNT_W(8)) u_ov (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .count_clr(count_clr),
    .detect(det_ov), .match_count(cnt_ov), .state_dbg(st_ov)
  );

  seq_detect_1011 #(.OVERLAP(0), .CNT_W(8)) u_no (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .count_clr(count_clr),
    .detect(det_no), .match_count(cnt_no), .state_dbg(st_no)
  );

  seq_detect_1011 #(.OVERLAP(0), .CNT_W(2)) u_c2 (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .count_clr(count_clr),
    .detect(det_c2), .match_count(cnt_c2), .state_dbg(st_c2)
  );

  // Reference model: instance 0 = overlap/8-bit, 1 = no overlap/8-bit,
  // 2 = no overlap/2-bit. Each keeps the last (up to) four consumed bits;
  // the non-overlapping variants forget their history after each match.
  logic [3:0] m_hist [3];
  int         m_hlen [3];
  bit         m_just [3];
  bit         m_det  [3];
  int         m_cnt  [3];
  int         m_ov   [3] = '{1, 0, 0};
  int         m_max  [3] = '{255, 255, 3};

  function automatic int exp_state(input int m);
    logic [3:0] pat;
    logic [3:0] tail;
    logic [3:0] pre;
    if (m_just[m]) return 4;
    pat = 4'b1011;
    for (int k = 3; k >= 1; k--) begin
      if (m_hlen[m] >= k) begin
        tail = m_hist[m] & 4'((1 << k) - 1);
        pre  = pat >> (4 - k);
        if (tail == pre) return k;
      end
    end
    return 0;
  endfunction

  task automatic model_edge(input logic b, input logic v, input logic c, input logic r);
    bit mt;
    for (int m = 0; m < 3; m++) begin
      if (r) begin
        m_hist[m] = 4'b0;
        m_hlen[m] = 0;
        m_just[m] = 1'b0;
        m_det[m]  = 1'b0;
        m_cnt[m]  = 0;
      end else begin
        mt = 1'b0;
        if (v) begin
          m_hist[m] = {m_hist[m][2:0], b};
          m_hlen[m] = (m_hlen[m] < 4) ? m_hlen[m] + 1 : 4;
          mt = (m_hlen[m] == 4) && (m_hist[m] == 4'b1011);
          m_just[m] = mt;
          if (mt && m_ov[m] == 0) begin
            m_hist[m] = 4'b0;
            m_hlen[m] = 0;
          end
        end
        m_det[m] = mt;
        if (c) m_cnt[m] = mt ? 1 : 0;
        else if (mt && m_cnt[m] < m_max[m]) m_cnt[m] = m_cnt[m] + 1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("ov.state",  32'(st_ov),  32'(exp_state(0)));
    chk("ov.detect", 32'(det_ov), 32'(m_det[0]));
    chk("ov.count",  32'(cnt_ov), 32'(m_cnt[0]));
    chk("no.state",  32'(st_no),  32'(exp_state(1)));
    chk("no.detect", 32'(det_no), 32'(m_det[1]));
    chk("no.count",  32'(cnt_no), 32'(m_cnt[1]));
    chk("c2.state",  32'(st_c2),  32'(exp_state(2)));
    chk("c2.detect", 32'(det_c2), 32'(m_det[2]));
    chk("c2.count",  32'(cnt_c2), 32'(m_cnt[2]));
  endtask

  task automatic step(input logic b, input logic v, input logic c, input logic r);
    bit_in    = b;
    bit_valid = v;
    count_clr = c;
    rst       = r;
    @(posedge clk);
    model_edge(b, v, c, r);
    #1;
    check_all();
  endtask

  task automatic bits(input logic [7:0] pat, input int n);
    for (int i = n - 1; i >= 0; i--) step(pat[i], 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset state
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("rst.state", 32'(st_ov), 32'd0);
    chk("rst.detect", 32'(det_ov), 32'd0);
    chk("rst.count", 32'(cnt_ov), 32'd0);

    // 1,0,1,1 walks the states; pulse only after the final bit
    step(1'b1, 1'b1, 1'b0, 1'b0); chk("tp1.s1", 32'(st_ov), 32'd1);
    step(1'b0, 1'b1, 1'b0, 1'b0); chk("tp1.s2", 32'(st_ov), 32'd2);
    step(1'b1, 1'b1, 1'b0, 1'b0); chk("tp1.s3", 32'(st_ov), 32'd3);
    chk("tp1.nodet", 32'(det_ov), 32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0); chk("tp1.s4", 32'(st_ov), 32'd4);
    chk("tp1.det", 32'(det_ov), 32'd1);
    chk("tp1.cnt", 32'(cnt_ov), 32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("tp1.hold_s4", 32'(st_ov), 32'd4);
    chk("tp1.pulse_end", 32'(det_ov), 32'd0);

    // Overlap vs non-overlap on 1011011
    step(1'b0, 1'b0, 1'b0, 1'b1);
    bits(8'b0101_1011, 7);
    chk("tp2.ov_cnt", 32'(cnt_ov), 32'd2);
    chk("tp2.ov_det", 32'(det_ov), 32'd1);
    chk("tp2.no_cnt", 32'(cnt_no), 32'd1);
    chk("tp2.no_det", 32'(det_no), 32'd0);

    // Gap of invalid cycles holds S101
    step(1'b0, 1'b0, 1'b0, 1'b1);
    bits(8'b0000_0101, 3);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      chk("tp3.gap_state", 32'(st_ov), 32'd3);
      chk("tp3.gap_det", 32'(det_ov), 32'd0);
    end
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("tp3.det", 32'(det_ov), 32'd1);

    // 2-bit counter saturation, then clear coinciding with a match
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      bits(8'b0000_1011, 4);
      chk("tp4.c2_cnt", 32'(cnt_c2), 32'((k < 3) ? k : 3));
    end
    bits(8'b0000_0101, 3);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("tp4.clr_match", 32'(cnt_c2), 32'd1);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk("tp4.clr_only", 32'(cnt_c2), 32'd0);

    // Reset mid-pattern
    step(1'b0, 1'b0, 1'b0, 1'b1);
    bits(8'b0000_0101, 3);
    chk("tp5.s3", 32'(st_ov), 32'd3);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("tp5.s0", 32'(st_ov), 32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("tp5.s1a", 32'(st_ov), 32'd1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("tp5.s1b", 32'(st_ov), 32'd1);
    chk("tp5.nodet", 32'(det_ov), 32'd0);
    chk("tp5.cnt", 32'(cnt_ov), 32'd0);

    // Prefix fallback S101 -> S10
    step(1'b0, 1'b0, 1'b0, 1'b1);
    bits(8'b0010_1011, 6);
    chk("tp6.det", 32'(det_ov), 32'd1);
    chk("tp6.cnt", 32'(cnt_ov), 32'd1);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(1)),
           ($urandom_range(99) < 75),
           ($urandom_range(99) < 3),
           ($urandom_range(199) < 1));
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule
